// File: rtl/pe_mac_fx_pkg.sv
// Shared definitions for the systolic MAC processing element: tag bit map,
// result-buffer states and width-generic sign-extend / saturate helpers.
package pe_pkg;

  localparam int unsigned TAG_VALID = 0;
  localparam int unsigned TAG_START = 1;
  localparam int unsigned TAG_FLUSH = 2;
  localparam int unsigned TAG_LAST  = 3;

  localparam logic [63:0] TAG_IDLE = '1;

  typedef enum logic {RES_EMPTY, RES_FULL} res_state_e;

  // Working width for helper arithmetic; must exceed ACC_WIDTH+1 and 2*WIDTH.
  localparam int unsigned PE_MAXW = 160;
  typedef logic signed [PE_MAXW-1:0] pe_wide_t;

  typedef struct packed {
    logic     clip;
    pe_wide_t val;
  } pe_sat_t;

  function automatic pe_wide_t sext(input pe_wide_t v, input int unsigned w);
    return (v <<< (PE_MAXW - w)) >>> (PE_MAXW - w);
  endfunction

  function automatic pe_sat_t sat_to(input pe_wide_t v, input int unsigned w);
    pe_sat_t  r;
    pe_wide_t hi;
    pe_wide_t lo;
    hi = (pe_wide_t'(1) <<< (w - 1)) - pe_wide_t'(1);
    lo = -hi - pe_wide_t'(1);
    r.clip = 1'b0;
    r.val  = v;
    if (v > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (v < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_fx_shift_sat.sv
// Accumulator readout: optional round-half-up (PE_ROUND_EN), arithmetic
// shift by FRAC and saturation to WIDTH with a clip flag. Purely combinational.
module pe_shift_sat
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ACC_WIDTH = 72,
  parameter int unsigned FRAC      = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0]     val_o,
  output logic                 clip_o
);

  localparam int unsigned RND_SH = (FRAC > 0) ? FRAC - 1 : 0;

  pe_wide_t acc_w;
  pe_sat_t  rnd;
  pe_sat_t  outv;

  always_comb begin
    acc_w    = sext(pe_wide_t'(acc_i), ACC_WIDTH);
    rnd.clip = 1'b0;
    rnd.val  = acc_w;
`ifdef PE_ROUND_EN
    if (FRAC > 0) begin
      rnd = sat_to(acc_w + (pe_wide_t'(1) <<< RND_SH), ACC_WIDTH);
    end
`endif
    outv   = sat_to(rnd.val >>> FRAC, WIDTH);
    val_o  = outv.val[WIDTH-1:0];
    clip_o = rnd.clip | outv.clip;
  end

endmodule

// File: rtl/pe_mac_fx.sv
// Systolic fixed-point MAC processing element: 1-cycle operand/tag forwarding,
// registered multiply, saturating accumulate, one-entry result buffer (PE_ROUND_EN selects readout rounding).
module pe_mac_fx
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ACC_WIDTH = 72,
  parameter int unsigned FRAC      = 16,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [TAG_WIDTH-1:0] t_i,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic [TAG_WIDTH-1:0] t_o,
  output logic [WIDTH-1:0]     s_o,
  output logic                 s_sat_o,
  output logic                 s_valid_o,
  input  logic                 s_ready_i,
  output logic                 ovf_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [TAG_WIDTH-1:0] t_q, t_d;
  logic [PW-1:0]        p_q, p_d;
  logic [3:0]           tag_q, tag_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_sat_q, acc_sat_d;
  res_state_e           state_q, state_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic                 s_sat_q, s_sat_d;
  logic                 ovf_q, ovf_d;

  logic                 flush, start, cap, cap_sat;
  pe_wide_t             base_w, add_w;
  pe_sat_t              acc_res;
  logic [ACC_WIDTH-1:0] sum_acc;
  logic [WIDTH-1:0]     rd_val;
  logic                 rd_clip;

  // Forwarding and multiplier stage; a flush keeps only its FLUSH bit so stage 2 still sees it.
  always_comb begin
    a_d   = a_i;
    b_d   = b_i;
    t_d   = t_i;
    tag_d = t_i[3:0];
    p_d   = PW'($signed(a_i)) * PW'($signed(b_i));
    if (t_i[TAG_FLUSH]) begin
      a_d            = '0;
      b_d            = '0;
      p_d            = '0;
      tag_d          = '0;
      tag_d[TAG_FLUSH] = 1'b1;
    end
  end

  always_comb begin
    flush     = tag_q[TAG_FLUSH];
    start     = tag_q[TAG_START];
    base_w    = start ? '0 : sext(pe_wide_t'(acc_q), ACC_WIDTH);
    add_w     = tag_q[TAG_VALID] ? sext(pe_wide_t'(p_q), PW) : '0;
    acc_res   = sat_to(base_w + add_w, ACC_WIDTH);
    sum_acc   = acc_res.val[ACC_WIDTH-1:0];
    acc_d     = flush ? '0 : sum_acc;
    acc_sat_d = flush ? 1'b0 : ((acc_sat_q & ~start) | acc_res.clip);
    cap       = ~flush & tag_q[TAG_LAST];
    cap_sat   = acc_sat_d | rd_clip;
  end

  pe_shift_sat #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .FRAC     (FRAC)
  ) u_shift_sat (
    .acc_i (sum_acc),
    .val_o (rd_val),
    .clip_o(rd_clip)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    s_sat_d = s_sat_q;
    ovf_d   = ovf_q;
    if (flush) begin
      state_d = RES_EMPTY;
      s_d     = '0;
      s_sat_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        RES_EMPTY: begin
          if (cap) begin
            state_d = RES_FULL;
            s_d     = rd_val;
            s_sat_d = cap_sat;
          end
        end
        RES_FULL: begin
          // Draining and refilling in the same cycle loses nothing.
          if (cap && s_ready_i) begin
            s_d     = rd_val;
            s_sat_d = cap_sat;
          end else if (cap) begin
            ovf_d = 1'b1;
          end else if (s_ready_i) begin
            state_d = RES_EMPTY;
          end
        end
        default: state_d = RES_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= TAG_IDLE[TAG_WIDTH-1:0];
      p_q       <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      state_q   <= RES_EMPTY;
      s_q       <= '0;
      s_sat_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      p_q       <= p_d;
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      state_q   <= state_d;
      s_q       <= s_d;
      s_sat_q   <= s_sat_d;
      ovf_q     <= ovf_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign t_o       = t_q;
  assign s_o       = s_q;
  assign s_sat_o   = s_sat_q;
  assign s_valid_o = (state_q == RES_FULL);
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pe_mac_fx.sv
// Scoreboard bench for pe_mac_fx: directed scenarios plus randomized tag/operand
// streams checked against an arithmetic dot-product model.
module tb_pe_mac_fx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_i, b_i, a_o, b_o, s_o;
  logic [7:0]  t_i, t_o;
  logic        s_sat_o, s_valid_o, s_ready_i, ovf_o;

  pe_mac_fx #(.WIDTH(32), .ACC_WIDTH(72), .FRAC(16), .TAG_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .t_i(t_i),
    .a_o(a_o), .b_o(b_o), .t_o(t_o), .s_o(s_o), .s_sat_o(s_sat_o),
    .s_valid_o(s_valid_o), .s_ready_i(s_ready_i), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        s;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_push_en = 1'b1;

  logic signed [127:0] m_acc = '0;
  bit                  m_sat = 1'b0;
  logic signed [127:0] ACC_MAX;
  logic signed [127:0] ACC_MIN;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Readout of a Q16 accumulation: optional round half up, floor shift, clamp to 32 bits.
  function automatic exp_t readout(input logic signed [127:0] acc, input bit asat);
    exp_t r;
    logic signed [127:0] v;
    bit clip;
    v = acc;
    clip = 1'b0;
`ifdef PE_ROUND_EN
    v = v + 128'sd32768;
    if (v > ACC_MAX) begin v = ACC_MAX; clip = 1'b1; end
`endif
    v = v >>> 16;
    if (v > 128'sd2147483647) begin v = 128'sd2147483647; clip = 1'b1; end
    if (v < -128'sd2147483648) begin v = -128'sd2147483648; clip = 1'b1; end
    r.v = v[31:0];
    r.s = asat | clip;
    return r;
  endfunction

  task automatic model_apply(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    logic signed [127:0] pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    if (t[2]) begin
      m_acc = '0;
      m_sat = 1'b0;
    end else begin
      if (t[1]) begin m_acc = '0; m_sat = 1'b0; end
      if (t[0]) m_acc = m_acc + pa * pb;
      if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
      if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
      if (t[3] && model_push_en) exp_q.push_back(readout(m_acc, m_sat));
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    a_i = a;
    b_i = b;
    t_i = t;
    model_apply(a, b, t);
    @(posedge clk);
    #1;
    check("fwd_a", {32'h0, a_o}, {32'h0, (t[2] ? 32'h0 : a)});
    check("fwd_b", {32'h0, b_o}, {32'h0, (t[2] ? 32'h0 : b)});
    check("fwd_t", {56'h0, t_o}, {56'h0, t});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && s_valid_o && s_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got s_o=%h sat=%b, expected no result", s_o, s_sat_o);
      end else begin
        e = exp_q.pop_front();
        if ({s_sat_o, s_o} !== {e.s, e.v}) begin
          n_bad++;
          $display("FAIL result: got s_o=%h sat=%b, expected s_o=%h sat=%b", s_o, s_sat_o, e.v, e.s);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra, rb;
  logic [7:0]  rt;

  initial begin
    ACC_MAX = (128'sd1 <<< 71) - 128'sd1;
    ACC_MIN = -(128'sd1 <<< 71);
    reset = 1'b0;
    a_i = '0; b_i = '0; t_i = 8'h00; s_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_o", {32'h0, a_o}, 64'h0);
    check("rst_t_o", {56'h0, t_o}, 64'hFF);
    check("rst_s", {31'h0, ovf_o, s_valid_o, s_sat_o, s_o}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    step(32'h0, 32'h0, 8'h00);

    // Single product 2.0 * 3.0.
    step(32'h0002_0000, 32'h0003_0000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
    check("single", {31'h0, s_valid_o, s_sat_o, s_o}, {31'h0, 1'b1, 1'b0, 32'h0006_0000});

    // 4-term dot product, then again with a bubble.
    step(32'h0001_0000, 32'h0000_8000, 8'h03);
    step(32'h0002_0000, 32'h0000_8000, 8'h01);
    step(32'h0003_0000, 32'h0000_8000, 8'h01);
    step(32'h0004_0000, 32'h0000_8000, 8'h09);
    step(32'h0, 32'h0, 8'h00);
    check("dot4", {32'h0, s_o}, 64'h0005_0000);
    step(32'h0001_0000, 32'h0000_8000, 8'h03);
    step(32'h0002_0000, 32'h0000_8000, 8'h01);
    step(32'h1234_5678, 32'h7654_3210, 8'h00);
    step(32'h0003_0000, 32'h0000_8000, 8'h01);
    step(32'h0004_0000, 32'h0000_8000, 8'h09);
    step(32'h0, 32'h0, 8'h00);
    check("dot4_bubble", {32'h0, s_o}, 64'h0005_0000);

    // Saturation at readout, positive and negative.
    step(32'h7FFF_0000, 32'h7FFF_0000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
    check("sat_pos", {31'h0, s_sat_o, s_o}, {31'h0, 1'b1, 32'h7FFF_FFFF});
    step(32'h8000_0000, 32'h7FFF_0000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
    check("sat_neg", {31'h0, s_sat_o, s_o}, {31'h0, 1'b1, 32'h8000_0000});

    // Readout rounding of half an LSB.
    step(32'h0000_0001, 32'h0000_8000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
`ifdef PE_ROUND_EN
    check("round", {32'h0, s_o}, 64'h1);
`else
    check("round", {32'h0, s_o}, 64'h0);
`endif

    // Backpressure: second result dropped, third loaded alongside the drain.
    repeat (3) step(32'h0, 32'h0, 8'h00);
    s_ready_i = 1'b0;
    model_push_en = 1'b0;
    step(32'h0001_0000, 32'h0001_0000, 8'h0B);
    step(32'h0002_0000, 32'h0001_0000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
    check("bp_hold", {30'h0, ovf_o, s_valid_o, s_o}, {30'h0, 1'b1, 1'b1, 32'h0001_0000});
    step(32'h0003_0000, 32'h0001_0000, 8'h0B);
    s_ready_i = 1'b1;
    exp_q.push_back('{v: 32'h0001_0000, s: 1'b0});
    exp_q.push_back('{v: 32'h0003_0000, s: 1'b0});
    step(32'h0, 32'h0, 8'h00);
    check("bp_refill", {30'h0, ovf_o, s_valid_o, s_o}, {30'h0, 1'b1, 1'b1, 32'h0003_0000});
    model_push_en = 1'b1;
    step(32'h0, 32'h0, 8'h00);

    // Flush mid-accumulation clears buffer and sticky overflow.
    step(32'h0001_0000, 32'h0001_0000, 8'h03);
    step(32'h0001_0000, 32'h0001_0000, 8'h01);
    step(32'h0005_0000, 32'h0006_0000, 8'h04);
    step(32'h0, 32'h0, 8'h00);
    check("flush", {62'h0, ovf_o, s_valid_o}, 64'h0);
    step(32'h0001_0000, 32'h0001_0000, 8'h0B);
    step(32'h0, 32'h0, 8'h00);
    check("after_flush", {32'h0, s_o}, 64'h0001_0000);

    // Asynchronous reset between clock edges.
    step(32'h0003_0000, 32'h0002_0000, 8'h0B);
    step(32'h0001_0000, 32'h0001_0000, 8'h03);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst", {15'h0, t_o, ovf_o, s_valid_o, s_sat_o, s_o}, {15'h0, 8'hFF, 3'b000, 32'h0});
    check("async_rst_fwd", {a_o, b_o}, 64'h0);
    void'(exp_q.pop_back());
    m_acc = '0;
    m_sat = 1'b0;
    a_i = '0; b_i = '0; t_i = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(32'h0, 32'h0, 8'h00);
    check("no_spurious", {63'h0, s_valid_o}, 64'h0);

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3: rt = 8'h01;
        4, 5:       rt = 8'h03;
        6:          rt = 8'h00;
        7, 8:       rt = 8'h09;
        9, 10:      rt = 8'h0B;
        11:         rt = 8'h08;
        12:         rt = 8'h02;
        13:         rt = 8'h04;
        14:         rt = 8'hFF;
        default:    rt = 8'(($urandom_range(0, 15) << 4) | 1);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        ra = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
        rb = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      step(ra, rb, rt);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(32'h0, 32'h0, 8'h00);
    step(32'h0, 32'h0, 8'h00);
    check("drain", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_mac_fx.md
Name: pe_mac_fx

Overview:
- Next-generation systolic processing element for the vertex-shader matrix/vector array.
- Forwards operands and tag east/south with one cycle of latency.
- Computes a signed fixed-point multiply-accumulate with a registered multiplier stage, a saturating wide accumulator and tag-driven start/last/flush control.
- Delivers each finished dot product through a one-entry valid/ready result buffer with overflow detection.

Parameters:
- WIDTH, 32: operand and result width, signed.
- ACC_WIDTH, 72: accumulator width; must be at least 2*WIDTH.
- FRAC, 16: fraction bits of the Q-format operands; applied as a right shift on result readout; 0 is legal.
- TAG_WIDTH, 8: tag width; must be at least 4.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- a_i  input  WIDTH  operand A, signed.
- b_i  input  WIDTH  operand B, signed.
- t_i  input  TAG_WIDTH  tag: bit0 VALID, bit1 START, bit2 FLUSH, bit3 LAST.
- a_o  output  WIDTH  forwarded A.
- b_o  output  WIDTH  forwarded B.
- t_o  output  TAG_WIDTH  forwarded tag.
- s_o  output  WIDTH  result, shifted and saturated.
- s_sat_o  output  1  result was clipped, at accumulator or readout.
- s_valid_o  output  1  result buffer full.
- s_ready_i  input  1  consumer accepts the result.
- ovf_o  output  1  sticky: a result was lost while the buffer was full.

Behaviour:
- Reset (reset=0, asynchronous): every output register and all internal state go to 0, except t_o=all-ones (idle tag, 0xFF).
- Forwarding: a_o/b_o/t_o <= a_i/b_i/t_i every cycle, latency 1.
  - If t_i[2] (FLUSH; includes idle 0xFF): a_o/b_o <= 0 and t_o <= t_i.
- Stage 1 (cycle N+1): p_r <= a_i*b_i, full 2*WIDTH signed product; tag_r <= t_i. FLUSH clears p_r and tag_r.
- Stage 2 (cycle N+2), driven by tag_r:
  - FLUSH: acc=0; result buffer emptied (s_valid_o=0, s_o=0, s_sat_o=0); ovf_o=0; no capture.
  - Otherwise base = START ? 0 : acc.
  - sum = base + (VALID ? sext(p_r) : 0).
  - The add saturates to signed ACC_WIDTH limits and sets an internal sticky acc_sat, which clears on START or FLUSH.
  - START without VALID loads acc=0.
  - LAST: capture value = sat_WIDTH(sum >>> FRAC), arithmetic shift, truncation toward negative infinity. s_sat_o <= acc_sat | readout clip.
  - LAST without VALID captures the current accumulation.
- Result buffer FSM, states EMPTY and FULL:
  - EMPTY + capture -> FULL: s_o loaded, s_valid_o=1.
  - FULL + s_ready_i -> EMPTY, unless a capture arrives in the same cycle. Then the new result is loaded and the state stays FULL: no loss, no ovf.
  - FULL + !s_ready_i + capture: the new result is discarded, s_o holds, ovf_o <= 1 (sticky until FLUSH or reset).
  - s_o and s_sat_o are stable while FULL; they are zeroed only by reset or FLUSH.
- START+LAST in one tag gives a single-product result.
- Result latency: LAST at input cycle N gives s_valid_o=1 at cycle N+2.

Optional Feature:
- PE_ROUND_EN defined: readout adds 1<<(FRAC-1) before the shift (round half up). The add saturates at ACC_WIDTH. With FRAC=0 no add is performed.
- Undefined: truncation as above.

Decomposition:
- Package pe_pkg:
  - tag bit indices TAG_VALID=0, TAG_START=1, TAG_FLUSH=2, TAG_LAST=3.
  - TAG_IDLE = all ones.
  - result FSM state typedef {RES_EMPTY, RES_FULL}.
  - sat/sext helper functions.
- Sub-module pe_shift_sat: combinational ACC_WIDTH->WIDTH rounding, shift, saturate and clip flag. Reused by the array drain logic.

Test Plan:
- Single product: WIDTH=32, FRAC=16, a_i=0x00020000, b_i=0x00030000, t_i=0x0B -> 2 cycles later s_o=0x00060000, s_valid_o=1, s_sat_o=0. a_o/b_o equal the inputs after 1 cycle.
- 4-term dot product: a=1.0,2.0,3.0,4.0 and b=0.5 each; tags 0x03,0x01,0x01,0x09 -> s_o=0x00050000 (5.0). Repeat with a bubble tag 0x00 mid-stream -> same result.
- Backpressure: s_ready_i=0, two results 1.0 then 2.0 -> s_o stays 0x00010000, ovf_o=1. Then s_ready_i=1 with a simultaneous third capture 3.0 -> s_o=0x00030000, s_valid_o stays 1, ovf_o stays 1.
- Saturation: a=b=0x7FFF0000, t_i=0x0B -> s_o=0x7FFFFFFF, s_sat_o=1. Negative case a=0x80000000, b=0x7FFF0000 -> s_o=0x80000000, s_sat_o=1.
- FLUSH mid-accumulation: after 2 VALID products, t_i=0x04 -> a_o/b_o=0, acc=0, s_valid_o=0, ovf_o=0. A following START|LAST 1.0*1.0 gives 0x00010000.
- Async reset: assert reset=0 between clock edges mid-stream -> outputs zero and t_o=0xFF immediately without a clock edge. Release -> no spurious s_valid_o. With PE_ROUND_EN: a=0x00000001, b=0x00008000 -> s_o=1; without it -> 0.
